// File: rtl/cond_eval.sv
// Evaluates a 3-bit condition code against the carry/zero flags, stalling while a
// flag load is pending, and returns the result over a valid/accept handshake.
module cond_eval #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             cIn,
  input  logic             zIn,
  input  logic             notFlagLoad,
  input  logic             req,
  input  logic [2:0]       cond,
  output logic             ready,
  output logic             valid,
  output logic             taken,
  input  logic             accept,
  output logic             notLoadPc,
  output logic [CNT_W-1:0] takenCount,
  output logic [CNT_W-1:0] notTakenCount,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       cond_q;
  logic             ready_q;
  logic             valid_q;
  logic             taken_q;
  logic             notLoadPc_q;
  logic [CNT_W-1:0] takenCount_q;
  logic [CNT_W-1:0] notTakenCount_q;
  logic [CNT_W-1:0] stallCount_q;

  logic             hit_d;
  logic [CNT_W-1:0] takenCount_d;
  logic [CNT_W-1:0] notTakenCount_d;
  logic [CNT_W-1:0] stallCount_d;

  always_comb begin
    hit_d = 1'b0;
    case (cond_q)
      3'b000: hit_d = 1'b1;
      3'b001: hit_d = 1'b0;
      3'b010: hit_d = cIn;
      3'b011: hit_d = !cIn;
      3'b100: hit_d = zIn;
      3'b101: hit_d = !zIn;
      3'b110: hit_d = cIn && !zIn;
      3'b111: hit_d = !cIn || zIn;
      default: hit_d = 1'b0;
    endcase
  end

  // Saturating increments: hold at all-ones instead of wrapping.
  always_comb begin
    takenCount_d    = (takenCount_q    == '1) ? takenCount_q    : takenCount_q    + 1'b1;
    notTakenCount_d = (notTakenCount_q == '1) ? notTakenCount_q : notTakenCount_q + 1'b1;
    stallCount_d    = (stallCount_q    == '1) ? stallCount_q    : stallCount_q    + 1'b1;
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q         <= IDLE;
      cond_q          <= '0;
      ready_q         <= 1'b1;
      valid_q         <= 1'b0;
      taken_q         <= 1'b0;
      notLoadPc_q     <= 1'b1;
      takenCount_q    <= '0;
      notTakenCount_q <= '0;
      stallCount_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            cond_q  <= cond;
            ready_q <= 1'b0;
            state_q <= notFlagLoad ? EVAL : WAIT;
          end
        end
        WAIT: begin
          stallCount_q <= stallCount_d;
          if (notFlagLoad) state_q <= EVAL;
        end
        EVAL: begin
          taken_q     <= hit_d;
          valid_q     <= 1'b1;
          notLoadPc_q <= !hit_d;
          if (hit_d) takenCount_q    <= takenCount_d;
          else       notTakenCount_q <= notTakenCount_d;
          state_q     <= RESULT;
        end
        RESULT: begin
          // PC load strobe lasts only the first RESULT cycle, however long accept takes.
          notLoadPc_q <= 1'b1;
          if (accept) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready         = ready_q;
  assign valid         = valid_q;
  assign taken         = taken_q;
  assign notLoadPc     = notLoadPc_q;
  assign takenCount    = takenCount_q;
  assign notTakenCount = notTakenCount_q;
  assign stallCount    = stallCount_q;

endmodule

// File: tb/tb_cond_eval.sv
// Directed bench for cond_eval: default-width instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_cond_eval;

  logic       clock = 1'b0;
  logic       notReset = 1'b0;
  logic       cIn = 1'b0;
  logic       zIn = 1'b0;
  logic       notFlagLoad = 1'b1;
  logic       req = 1'b0;
  logic [2:0] cond = 3'b000;
  logic       accept = 1'b0;

  logic       ready, valid, taken, notLoadPc;
  logic [7:0] takenCount, notTakenCount, stallCount;

  logic       ready2, valid2, taken2, notLoadPc2;
  logic [1:0] takenCount2, notTakenCount2, stallCount2;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  cond_eval #(.CNT_W(8)) dut (
    .clock(clock), .notReset(notReset), .cIn(cIn), .zIn(zIn),
    .notFlagLoad(notFlagLoad), .req(req), .cond(cond),
    .ready(ready), .valid(valid), .taken(taken), .accept(accept),
    .notLoadPc(notLoadPc), .takenCount(takenCount),
    .notTakenCount(notTakenCount), .stallCount(stallCount)
  );

  cond_eval #(.CNT_W(2)) dut2 (
    .clock(clock), .notReset(notReset), .cIn(cIn), .zIn(zIn),
    .notFlagLoad(notFlagLoad), .req(req), .cond(cond),
    .ready(ready2), .valid(valid2), .taken(taken2), .accept(accept),
    .notLoadPc(notLoadPc2), .takenCount(takenCount2),
    .notTakenCount(notTakenCount2), .stallCount(stallCount2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction with no pending flag load, accepted in the first RESULT cycle.
  task automatic txn(input string tag, input logic [2:0] c, input logic exp_t);
    req  = 1'b1;
    cond = c;
    tick();
    req  = 1'b0;
    cond = ~c;
    chk({tag, "_busy"}, {7'd0, ready}, 8'd0);
    tick();
    chk({tag, "_valid"}, {7'd0, valid}, 8'd1);
    chk({tag, "_taken"}, {7'd0, taken}, {7'd0, exp_t});
    chk({tag, "_nlpc"}, {7'd0, notLoadPc}, {7'd0, !exp_t});
    accept = 1'b1;
    tick();
    accept = 1'b0;
    chk({tag, "_done"}, {6'd0, ready, valid}, 8'b10);
    chk({tag, "_nlpc_off"}, {7'd0, notLoadPc}, 8'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_nlpc", {7'd0, notLoadPc}, 8'd1);
    chk("rst_cnt", takenCount | notTakenCount | stallCount, 8'd0);
    @(negedge clock);
    notReset = 1'b1;
    tick();

    // C branch taken, explicit latency
    cIn = 1'b1; zIn = 1'b0; notFlagLoad = 1'b1;
    req = 1'b1; cond = 3'b010;
    tick();
    req = 1'b0;
    chk("t1_eval_valid", {7'd0, valid}, 8'd0);
    chk("t1_eval_ready", {7'd0, ready}, 8'd0);
    tick();
    chk("t1_valid", {7'd0, valid}, 8'd1);
    chk("t1_taken", {7'd0, taken}, 8'd1);
    chk("t1_nlpc", {7'd0, notLoadPc}, 8'd0);
    chk("t1_tcnt", takenCount, 8'd1);
    accept = 1'b1;
    tick();
    accept = 1'b0;
    chk("t1_idle", {6'd0, ready, valid}, 8'b10);

    // C&&!Z and !C||Z with C=0 Z=1
    cIn = 1'b0; zIn = 1'b1;
    txn("t2a", 3'b110, 1'b0);
    chk("t2a_ntcnt", notTakenCount, 8'd1);
    txn("t2b", 3'b111, 1'b1);
    chk("t2b_tcnt", takenCount, 8'd2);

    // Pending flag load for three cycles; Z updates on the load edge
    zIn = 1'b0; notFlagLoad = 1'b0;
    req = 1'b1; cond = 3'b100;
    tick();
    req = 1'b0;
    chk("t3_wait_ready", {7'd0, ready}, 8'd0);
    tick();
    chk("t3_stall1", stallCount, 8'd1);
    tick();
    notFlagLoad = 1'b1; zIn = 1'b1;
    tick();
    chk("t3_stall3", stallCount, 8'd3);
    chk("t3_not_yet", {7'd0, valid}, 8'd0);
    tick();
    chk("t3_valid", {7'd0, valid}, 8'd1);
    chk("t3_taken", {7'd0, taken}, 8'd1);
    chk("t3_nlpc", {7'd0, notLoadPc}, 8'd0);

    // Delayed accept: stable result, strobe only first cycle, req ignored
    req = 1'b1; cond = 3'b000; zIn = 1'b0; cIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_valid", {7'd0, valid}, 8'd1);
      chk("t4_taken", {7'd0, taken}, 8'd1);
      chk("t4_nlpc", {7'd0, notLoadPc}, 8'd1);
      chk("t4_ready", {7'd0, ready}, 8'd0);
    end
    req = 1'b0; accept = 1'b1;
    tick();
    accept = 1'b0;
    chk("t4_idle", {6'd0, ready, valid}, 8'b10);
    chk("t4_tcnt", takenCount, 8'd3);
    chk("t4_stall", stallCount, 8'd3);
    tick();
    chk("t4_no_queue", {6'd0, ready, valid}, 8'b10);

    // Reset in the middle of WAIT
    notFlagLoad = 1'b0;
    req = 1'b1; cond = 3'b001;
    tick();
    req = 1'b0;
    tick();
    #2;
    notReset = 1'b0;
    #1;
    chk("t5w_ready", {7'd0, ready}, 8'd1);
    chk("t5w_valid", {7'd0, valid}, 8'd0);
    chk("t5w_cnt", takenCount | notTakenCount | stallCount, 8'd0);
    notReset = 1'b1;
    notFlagLoad = 1'b1;
    tick();

    // Reset in the middle of RESULT while the PC strobe is low
    req = 1'b1; cond = 3'b000;
    tick();
    req = 1'b0;
    tick();
    chk("t5r_nlpc_pre", {7'd0, notLoadPc}, 8'd0);
    chk("t5r_tcnt_pre", takenCount, 8'd1);
    #2;
    notReset = 1'b0;
    #1;
    chk("t5r_nlpc", {7'd0, notLoadPc}, 8'd1);
    chk("t5r_valid", {7'd0, valid}, 8'd0);
    chk("t5r_ready", {7'd0, ready}, 8'd1);
    chk("t5r_tcnt", takenCount, 8'd0);
    notReset = 1'b1;
    tick();

    // Normal operation after reset, then saturation of the narrow instance
    cIn = 1'b0; zIn = 1'b0;
    txn("t6a", 3'b011, 1'b1);
    chk("t6a_tcnt", takenCount, 8'd1);
    txn("t6b", 3'b001, 1'b0);
    txn("t6c", 3'b101, 1'b1);
    cIn = 1'b1;
    txn("t6d", 3'b010, 1'b1);
    txn("t6e", 3'b000, 1'b1);
    txn("t6f", 3'b011, 1'b0);
    chk("t6_tcnt2_before", {6'd0, takenCount2}, 8'd3);
    txn("t6g", 3'b110, 1'b1);
    chk("t6_tcnt", takenCount, 8'd5);
    chk("t6_ntcnt", notTakenCount, 8'd2);
    chk("t6_tcnt2_sat", {6'd0, takenCount2}, 8'd3);
    chk("t6_ntcnt2", {6'd0, notTakenCount2}, 8'd2);
    chk("t6_stall", stallCount, 8'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_eval.md
Name: cond_eval

Overview:
- Flag consumer for the status register: takes a 3-bit condition code from the sequencer and evaluates it against the registered carry/zero flags.
- Returns a taken/not-taken result through a req/ack and valid/accept handshake.
- Drives the active-low PC load strobe for conditional jumps.
- Stalls when a flag update is in flight, so it never evaluates stale flags. Keeps saturating taken/not-taken statistics for the simulation benches.

Parameters:
CNT_W, 8, width of each saturating statistics counter (takenCount, notTakenCount, stallCount).

Ports:
clock  input  1  system clock, rising edge.
notReset  input  1  asynchronous, active-low reset.
cIn  input  1  carry flag from status register output.
zIn  input  1  zero flag from status register output.
notFlagLoad  input  1  status register load strobe (active low); low means flags change at the next edge.
req  input  1  evaluation request from sequencer.
cond  input  3  condition code, sampled only on acceptance.
ready  output  1  high in IDLE; req&&ready at a rising edge means accepted.
valid  output  1  result available.
taken  output  1  condition result, meaningful while valid.
accept  input  1  consumer takes result; valid&&accept at an edge completes the transaction.
notLoadPc  output  1  active-low PC load; low for exactly the first RESULT cycle when taken.
takenCount  output  CNT_W  saturating count of taken results.
notTakenCount  output  CNT_W  saturating count of not-taken results.
stallCount  output  CNT_W  saturating count of cycles spent in WAIT.

Behaviour:
- Reset (notReset low, asynchronous): state=IDLE; ready=1; valid=0; taken=0; notLoadPc=1; all counters=0; latched cond=000. Release is sampled on the next rising clock edge.
- Condition codes:
  - 000 always
  - 001 never
  - 010 C
  - 011 !C
  - 100 Z
  - 101 !Z
  - 110 C&&!Z
  - 111 !C||Z
- States: IDLE, WAIT, EVAL, RESULT (2-bit encoding, one-hot not required).
- IDLE:
  - ready=1.
  - On req at the edge: latch cond.
  - If notFlagLoad==0 in that same cycle, go to WAIT; otherwise go to EVAL.
  - req without ready is ignored; there is no queueing.
- WAIT:
  - ready=0. stallCount increments per cycle, saturating at all-ones.
  - At each edge where notFlagLoad==1, go to EVAL; stay otherwise. Back-to-back flag loads extend the stall indefinitely.
- EVAL:
  - Flags sampled this cycle are post-update.
  - At the edge: register taken from latched cond and cIn/zIn, go to RESULT.
  - Increment takenCount or notTakenCount (saturating).
- RESULT:
  - valid=1 and taken held stable until accept.
  - notLoadPc = !taken during the first RESULT cycle only, then 1, even if accept is delayed.
  - At an edge with accept: valid drops, return to IDLE.
  - Accepting in the first RESULT cycle is legal. A new req is accepted no earlier than the IDLE cycle that follows.
- Latency: acceptance at edge N with no pending flag load gives EVAL in cycle N..N+1 and valid high after edge N+1. Each pending-flag cycle adds one cycle.
- cond changes after acceptance have no effect. Flag changes outside EVAL have no effect on the current result.
- X on cIn/zIn during EVAL propagates to taken; it is not masked.
- Reset mid-transaction aborts immediately: valid falls, and notLoadPc returns to 1 with no glitch low. The pending result is discarded and not counted.
- accept outside RESULT is ignored.

Test Plan:
- Reset, then flags C=1 Z=0 and notFlagLoad=1. req with cond=010 at edge 1 -> valid=1 and taken=1 after edge 2; notLoadPc=0 for one cycle; takenCount=1.
- Flags C=0 Z=1; cond=110 -> taken=0, notLoadPc stays 1, notTakenCount=1. Then cond=111 -> taken=1.
- req with cond=100 while notFlagLoad=0 for 3 cycles and zIn switching 0->1 on the load edge -> state passes through WAIT, stallCount=3, taken=1 (post-update Z used).
- accept held low 5 cycles in RESULT -> valid and taken stable for 5 cycles, notLoadPc low only in the first; req during RESULT is ignored (ready=0).
- Assert notReset low in mid-WAIT and again in mid-RESULT -> immediate IDLE, ready=1, valid=0, notLoadPc=1, counters 0; the next transaction behaves normally.
- CNT_W=2: issue 5 taken results -> takenCount saturates at 3, no wrap.
